// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, clocked-out frame from the
// device, ack sampling, and a shared timeout on every wait for the device.
module ps2_host_tx #(
  parameter int INHIBIT = 6000,
  parameter int TIMEOUT = 1000000,
  parameter int CW      = 20
) (
  input  logic       clock,
  input  logic       reset,
  inout  wire  [1:0] ps2,
  input  logic       strb,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       error
);

  typedef enum logic [1:0] {S_IDLE, S_INHIBIT, S_SEND, S_WAIT} state_t;

  localparam logic [CW-1:0] INH_END = CW'(INHIBIT - 1);
  localparam logic [CW-1:0] TO_END  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t        state, state_n;
  logic          ck_low, ck_low_n;
  logic          d_low, d_low_n;
  logic          busy_n, done_n, error_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [3:0]    bit_idx, bit_n;
  logic [9:0]    shift, shift_n;

  logic [1:0]    sync_p0, sync_p1;
  logic          ck_hist;
  logic          ck_sync, d_sync, fall;

  assign ps2[0] = ck_low ? 1'b0 : 1'bz;
  assign ps2[1] = d_low  ? 1'b0 : 1'bz;

  // Input stage: two-flop synchronisers plus a clock-line history flop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_p0 <= 2'b11;
      sync_p1 <= 2'b11;
      ck_hist <= 1'b1;
    end else begin
      sync_p0 <= ps2;
      sync_p1 <= sync_p0;
      ck_hist <= sync_p1[0];
    end
  end

  assign ck_sync = sync_p1[0];
  assign d_sync  = sync_p1[1];
  assign fall    = ck_hist & ~ck_sync;
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  // Control stage: state and registered line drivers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      ck_low  <= 1'b0;
      d_low   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      cnt     <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_n;
      ck_low  <= ck_low_n;
      d_low   <= d_low_n;
      busy    <= busy_n;
      done    <= done_n;
      error   <= error_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
    end
  end

  always_ff @(posedge clock) begin
    shift <= shift_n;
  end

  always_comb begin
    state_n  = state;
    ck_low_n = ck_low;
    d_low_n  = d_low;
    busy_n   = busy;
    done_n   = 1'b0;
    error_n  = error;
    cnt_n    = cnt;
    bit_n    = bit_idx;
    shift_n  = shift;
    unique case (state)
      S_IDLE: begin
        // A request coinciding with the done pulse belongs to the old transfer.
        if (strb && !busy && !done) begin
          shift_n  = {1'b1, ~^data, data};
          busy_n   = 1'b1;
          error_n  = 1'b0;
          ck_low_n = 1'b1;
          cnt_n    = '0;
          state_n  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt == INH_END) begin
          d_low_n  = 1'b1;
          ck_low_n = 1'b0;
          cnt_n    = '0;
          bit_n    = '0;
          state_n  = S_SEND;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      S_SEND: begin
        if (fall) begin
          cnt_n = '0;
          if (bit_idx == 4'd10) begin
            error_n = d_sync;
            bit_n   = 4'd11;
            state_n = S_WAIT;
          end else begin
            d_low_n = ~shift[bit_idx];
            bit_n   = bit_idx + 4'd1;
          end
        end else if (cnt == TO_END) begin
          ck_low_n = 1'b0;
          d_low_n  = 1'b0;
          error_n  = 1'b1;
          done_n   = 1'b1;
          busy_n   = 1'b0;
          bit_n    = '0;
          cnt_n    = '0;
          state_n  = S_IDLE;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      S_WAIT: begin
        if (ck_sync && d_sync) begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
          bit_n   = '0;
          cnt_n   = '0;
          state_n = S_IDLE;
        end else if (cnt == TO_END) begin
          ck_low_n = 1'b0;
          d_low_n  = 1'b0;
          error_n  = 1'b1;
          done_n   = 1'b1;
          busy_n   = 1'b0;
          bit_n    = '0;
          cnt_n    = '0;
          state_n  = S_IDLE;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the
// host, and received frames are compared against the byte's expected framing.
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TO  = 300;
  localparam int CW  = 12;
  localparam int H   = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       strb  = 1'b0;
  logic [7:0] data  = 8'h00;
  logic       busy, done, error;
  wire  [1:0] ps2;
  logic       dev_ck = 1'b0;
  logic       dev_d  = 1'b0;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic done_err = 1'b0;

  pullup (ps2[0]);
  pullup (ps2[1]);
  assign ps2[0] = dev_ck ? 1'b0 : 1'bz;
  assign ps2[1] = dev_d  ? 1'b0 : 1'bz;

  always #5 clock = ~clock;

  ps2_host_tx #(.INHIBIT(INH), .TIMEOUT(TO), .CW(CW)) dut (
    .clock(clock), .reset(reset), .ps2(ps2), .strb(strb), .data(data),
    .busy(busy), .done(done), .error(error)
  );

  always @(negedge clock) begin
    if (done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_err <= error;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // Expected wire frame after the start bit: data LSB first, odd parity, stop.
  function automatic logic [9:0] frame_of(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b};
  endfunction

  task automatic pulse_strb(input logic [7:0] b);
    @(negedge clock);
    strb = 1'b1;
    data = b;
    @(negedge clock);
    strb = 1'b0;
    data = 8'($urandom);
  endtask

  // Device model: waits for request-to-send, generates 11 clocks, samples on
  // rising edges, optionally acks; rst_fall > 0 asserts reset at that fall.
  task automatic device(input bit ack, input int rst_fall,
                        output logic [9:0] rx, output bit ok);
    int n = 0;
    ok = 1'b1;
    rx = '0;
    while (!(ps2[0] === 1'b1 && ps2[1] === 1'b0) && n < INH + 20) begin
      @(negedge clock);
      n++;
    end
    if (n >= INH + 20) begin
      ok = 1'b0;
      return;
    end
    repeat (5) @(negedge clock);
    for (int i = 1; i <= 11; i++) begin
      if (i == 11 && ack) dev_d = 1'b1;
      repeat (H / 2) @(negedge clock);
      dev_ck = 1'b1;
      if (i == rst_fall) begin
        repeat (4) @(negedge clock);
        checks++;
        if (ps2[1] !== 1'b0) begin
          errors++;
          $display("FAIL pre_reset_data_low: got %b expected 0", ps2[1]);
        end
        reset  = 1'b0;
        dev_ck = 1'b0;
        #1;
        ok = 1'b0;
        return;
      end
      repeat (H) @(negedge clock);
      if (i <= 10) rx[i-1] = ps2[1];
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_during_send: got %b expected 1 at clock %0d", busy, i);
      end
      dev_ck = 1'b0;
      repeat (H / 2) @(negedge clock);
    end
    repeat (H) @(negedge clock);
    dev_d = 1'b0;
  endtask

  task automatic wait_done(input int start, output bit got, output logic err);
    for (int k = 0; k < 60 && done_cnt == start; k++) @(negedge clock);
    got = (done_cnt != start);
    err = done_err;
  endtask

  task automatic xfer(input logic [7:0] b, input bit ack, input string name);
    logic [9:0] rx;
    bit ok, got;
    logic err;
    int start = done_cnt;
    pulse_strb(b);
    device(ack, 0, rx, ok);
    wait_done(start, got, err);
    checks++;
    if (!ok || rx !== frame_of(b)) begin
      errors++;
      $display("FAIL %s_frame: got %h expected %h (ok=%0d)", name, rx, frame_of(b), ok);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_done: got no done pulse expected one", name);
    end
    checks++;
    if (err !== !ack) begin
      errors++;
      $display("FAIL %s_error: got %b expected %b", name, err, !ack);
    end
    @(negedge clock);
    checks++;
    if (ps2 !== 2'b11 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: got ps2=%b busy=%b expected ps2=11 busy=0", name, ps2, busy);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({busy, done, error} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000", {busy, done, error});
    end
    checks++;
    if (ps2 !== 2'b11) begin
      errors++;
      $display("FAIL reset_lines: got %b expected 11", ps2);
    end
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_send_ed();
    xfer(8'hED, 1'b1, "send_ed");
  endtask

  task automatic test_back_to_back();
    xfer(8'h01, 1'b1, "b2b_01");
    xfer(8'hFF, 1'b1, "b2b_ff");
    for (int i = 0; i < 3; i++) xfer(8'($urandom), 1'b1, "b2b_rand");
  endtask

  task automatic test_no_ack();
    xfer(8'($urandom), 1'b0, "no_ack");
    repeat (10) @(negedge clock);
    checks++;
    if (error !== 1'b1) begin
      errors++;
      $display("FAIL no_ack_error_held: got %b expected 1", error);
    end
    xfer(8'($urandom), 1'b1, "after_no_ack");
  endtask

  task automatic test_timeout();
    int k = 0;
    @(negedge clock);
    strb = 1'b1;
    data = 8'($urandom);
    @(negedge clock);
    strb = 1'b0;
    checks++;
    if (ps2 !== 2'b10) begin
      errors++;
      $display("FAIL timeout_clock_low: got %b expected 10", ps2);
    end
    while (k < INH - 1) begin @(negedge clock); k++; end
    checks++;
    if (ps2 !== 2'b10) begin
      errors++;
      $display("FAIL timeout_inhibit_end: got %b expected 10", ps2);
    end
    @(negedge clock);
    k++;
    checks++;
    if (ps2 !== 2'b01) begin
      errors++;
      $display("FAIL timeout_rts: got %b expected 01", ps2);
    end
    while (done !== 1'b1 && k < INH + TO + 10) begin @(negedge clock); k++; end
    checks++;
    if (k < INH + TO || k > INH + TO + 3) begin
      errors++;
      $display("FAIL timeout_latency: got %0d cycles expected %0d..%0d", k, INH + TO, INH + TO + 3);
    end
    checks++;
    if (error !== 1'b1 || ps2 !== 2'b11) begin
      errors++;
      $display("FAIL timeout_abort: got error=%b ps2=%b expected error=1 ps2=11", error, ps2);
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic test_ignored_strb();
    logic [9:0] rx;
    bit ok, got;
    logic err;
    int start = done_cnt;
    logic [7:0] b;
    b = 8'($urandom);
    if (b == 8'h55) b = 8'hA3;
    fork
      begin
        pulse_strb(b);
        device(1'b1, 0, rx, ok);
      end
      begin
        repeat (INH + 60) @(negedge clock);
        strb = 1'b1;
        data = 8'h55;
        @(negedge clock);
        strb = 1'b0;
      end
    join
    wait_done(start, got, err);
    checks++;
    if (!ok || rx !== frame_of(b)) begin
      errors++;
      $display("FAIL ignored_strb_frame: got %h expected %h", rx, frame_of(b));
    end
    checks++;
    if (!got || err !== 1'b0) begin
      errors++;
      $display("FAIL ignored_strb_done: got done=%0d error=%b expected done=1 error=0", got, err);
    end
    repeat (20) @(negedge clock);
    checks++;
    if (done_cnt != start + 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignored_strb_single: got %0d transfers busy=%b expected 1 busy=0", done_cnt - start, busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] rx;
    bit ok;
    logic [7:0] b;
    b = 8'($urandom);
    b[4] = 1'b0;
    pulse_strb(b);
    device(1'b1, 5, rx, ok);
    checks++;
    if (ps2 !== 2'b11) begin
      errors++;
      $display("FAIL reset_mid_lines: got %b expected 11", ps2);
    end
    checks++;
    if ({busy, done, error} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %b expected 000", {busy, done, error});
    end
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    xfer(8'($urandom), 1'b1, "after_reset");
  endtask

  initial begin
    test_reset();
    test_send_ed();
    test_back_to_back();
    test_no_ack();
    test_timeout();
    test_ignored_strb();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
